// File: rtl/phase_sequencer.sv
// Instruction-cycle controller: steps the CPU through FETCH/DECODE/EXEC/WB under
// run, single-step and halt control, with a watchdog on the memory fetch handshake.
module phase_sequencer #(
    parameter int              OP_W     = 4,
    parameter logic [OP_W-1:0] HALT_OP  = 4'hF,
    parameter int              WAIT_MAX = 8,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             mem_ready,
    input  logic [OP_W-1:0]  opcode,
    output logic [1:0]       phase,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             mem_req,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              step_mode, step_next;
    logic              halt_pend, pend_next;
    logic [OP_W-1:0]   op_q, op_next;
    logic              tmo_next;
    logic [CNT_W-1:0]  count_next;
    logic              in_flight;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            step_mode   <= 1'b0;
            halt_pend   <= 1'b0;
            op_q        <= '0;
            timeout_err <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            step_mode   <= step_next;
            halt_pend   <= pend_next;
            op_q        <= op_next;
            timeout_err <= tmo_next;
            instr_count <= count_next;
        end
    end

    assign in_flight = (state == FETCH) || (state == DECODE) ||
                       (state == EXEC)  || (state == WB);

    // A halt request seen during WB still halts at this boundary, not the next one.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        step_next  = step_mode;
        pend_next  = halt_pend | (in_flight & halt_req);
        op_next    = op_q;
        tmo_next   = timeout_err;
        count_next = instr_count;
        case (state)
            IDLE: begin
                if (step) begin
                    state_next = FETCH;
                    step_next  = 1'b1;
                end else if (run) begin
                    state_next = FETCH;
                    step_next  = 1'b0;
                end else if (halt_req) begin
                    state_next = HALT;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    state_next = DECODE;
                    wait_next  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = HALT;
                    tmo_next   = 1'b1;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            DECODE: begin
                op_next    = opcode;
                state_next = EXEC;
            end
            EXEC: state_next = WB;
            WB: begin
                count_next = instr_count + CNT_W'(1);
                if ((op_q == HALT_OP) || pend_next) state_next = HALT;
                else if (step_mode)                 state_next = IDLE;
                else if (run)                       state_next = FETCH;
                else                                state_next = IDLE;
            end
            HALT: begin
                if (run && !halt_req && !timeout_err) begin
                    state_next = FETCH;
                    step_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        if ((state_next == HALT) && (state != HALT)) pend_next = 1'b0;
    end

    always_comb begin
        phase     = 2'b00;
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        wb_en     = 1'b0;
        mem_req   = 1'b0;
        halted    = 1'b0;
        busy      = in_flight;
        case (state)
            FETCH: begin
                fetch_en = 1'b1;
                mem_req  = 1'b1;
            end
            DECODE: begin
                phase     = 2'b01;
                decode_en = 1'b1;
            end
            EXEC: begin
                phase   = 2'b10;
                exec_en = 1'b1;
            end
            WB: begin
                phase = 2'b11;
                wb_en = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: phase  = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios with literal expectations, then
// randomized control traffic checked every cycle against an instruction-level model.
module tb_phase_sequencer;

    localparam int WAIT_MAX = 8;
    localparam int CNT_W    = 16;

    logic             clk;
    logic             clear;
    logic             run;
    logic             step;
    logic             halt_req;
    logic             mem_ready;
    logic [3:0]       opcode;
    logic [1:0]       phase;
    logic             fetch_en;
    logic             decode_en;
    logic             exec_en;
    logic             wb_en;
    logic             mem_req;
    logic             busy;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] instr_count;

    int check_count = 0;
    int pass_count  = 0;

    phase_sequencer #(
        .OP_W(4),
        .HALT_OP(4'hF),
        .WAIT_MAX(WAIT_MAX),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .clear(clear),
        .run(run),
        .step(step),
        .halt_req(halt_req),
        .mem_ready(mem_ready),
        .opcode(opcode),
        .phase(phase),
        .fetch_en(fetch_en),
        .decode_en(decode_en),
        .exec_en(exec_en),
        .wb_en(wb_en),
        .mem_req(mem_req),
        .busy(busy),
        .halted(halted),
        .timeout_err(timeout_err),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level model: either an instruction is in flight at some stage
    // (0 fetch .. 3 writeback), or the machine is parked idle or halted.
    bit        m_active;
    int        m_stage;
    bit        m_halted;
    bit        m_single;
    bit        m_stop;
    int        m_waited;
    bit [3:0]  m_op;
    bit        m_tmo;
    bit [15:0] m_count;

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_active <= 0;
            m_stage  <= 0;
            m_halted <= 0;
            m_single <= 0;
            m_stop   <= 0;
            m_waited <= 0;
            m_op     <= 0;
            m_tmo    <= 0;
            m_count  <= 0;
        end else if (m_active) begin
            if (halt_req) m_stop <= 1;
            if (m_stage == 0) begin
                if (mem_ready) begin
                    m_stage  <= 1;
                    m_waited <= 0;
                end else if (m_waited == WAIT_MAX - 1) begin
                    m_active <= 0;
                    m_halted <= 1;
                    m_tmo    <= 1;
                    m_stop   <= 0;
                    m_waited <= 0;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (m_stage == 1) begin
                m_op    <= opcode;
                m_stage <= 2;
            end else if (m_stage == 2) begin
                m_stage <= 3;
            end else begin
                m_count <= m_count + 16'd1;
                if (m_op == 4'hF || m_stop || halt_req) begin
                    m_active <= 0;
                    m_halted <= 1;
                    m_stop   <= 0;
                end else if (m_single || !run) begin
                    m_active <= 0;
                end else begin
                    m_stage <= 0;
                end
            end
        end else if (m_halted) begin
            if (run && !halt_req && !m_tmo) begin
                m_halted <= 0;
                m_active <= 1;
                m_stage  <= 0;
                m_single <= 0;
            end
        end else begin
            if (step) begin
                m_active <= 1;
                m_stage  <= 0;
                m_single <= 1;
            end else if (run) begin
                m_active <= 1;
                m_stage  <= 0;
                m_single <= 0;
            end else if (halt_req) begin
                m_halted <= 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        checkOutput("cyc_phase",     32'(phase),       m_active ? 32'(m_stage) : 32'd0);
        checkOutput("cyc_fetch_en",  32'(fetch_en),    32'(m_active && m_stage == 0));
        checkOutput("cyc_decode_en", 32'(decode_en),   32'(m_active && m_stage == 1));
        checkOutput("cyc_exec_en",   32'(exec_en),     32'(m_active && m_stage == 2));
        checkOutput("cyc_wb_en",     32'(wb_en),       32'(m_active && m_stage == 3));
        checkOutput("cyc_mem_req",   32'(mem_req),     32'(m_active && m_stage == 0));
        checkOutput("cyc_busy",      32'(busy),        32'(m_active));
        checkOutput("cyc_halted",    32'(halted),      32'(m_halted));
        checkOutput("cyc_timeout",   32'(timeout_err), 32'(m_tmo));
        checkOutput("cyc_count",     32'(instr_count), 32'(m_count));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        #2;
        clear = 1'b0;
    endtask

    task automatic applyStimulus(input int ready_pct);
        @(negedge clk);
        #1;
        if ($urandom_range(0, 149) == 0) pulseClear();
        run       = ($urandom_range(0, 99) < 80);
        step      = ($urandom_range(0, 9) == 0);
        halt_req  = ($urandom_range(0, 24) == 0);
        mem_ready = ($urandom_range(0, 99) < ready_pct);
        opcode    = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        mem_ready = 1'b0; opcode = 4'h0;
        #1 clear = 1'b1;
        repeat (2) @(negedge clk);
        #1 clear = 1'b0;
        checkOutput("rst_phase",   32'(phase), 0);
        checkOutput("rst_busy",    32'(busy), 0);
        checkOutput("rst_halted",  32'(halted), 0);
        checkOutput("rst_count",   32'(instr_count), 0);
        checkOutput("rst_timeout", 32'(timeout_err), 0);

        // Free run with memory always ready: 4 cycles per instruction.
        run = 1'b1; mem_ready = 1'b1; opcode = 4'h0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            checkOutput("run_phase", 32'(phase), 32'(k % 4));
            checkOutput("run_count", 32'(instr_count), 32'(k / 4));
        end
        run = 1'b0;
        cyc(1);
        checkOutput("run_stop_busy",  32'(busy), 0);
        checkOutput("run_stop_count", 32'(instr_count), 3);

        // Single step from IDLE.
        pulseClear();
        step = 1'b1;
        cyc(1);
        checkOutput("step_fetch", 32'(fetch_en), 1);
        step = 1'b0;
        cyc(4);
        checkOutput("step_idle_busy", 32'(busy), 0);
        checkOutput("step_count",     32'(instr_count), 1);

        // Three stall cycles in FETCH.
        run = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            checkOutput("stall_mem_req", 32'(mem_req), 1);
        end
        mem_ready = 1'b1;
        cyc(1);
        checkOutput("stall_decode",  32'(decode_en), 1);
        checkOutput("stall_req_off", 32'(mem_req), 0);
        run = 1'b0;
        cyc(3);
        checkOutput("stall_done_busy", 32'(busy), 0);

        // Fetch watchdog expiry.
        pulseClear();
        run = 1'b1; mem_ready = 1'b0;
        cyc(8);
        checkOutput("wd_still_fetch", 32'(mem_req), 1);
        checkOutput("wd_not_halted",  32'(halted), 0);
        cyc(1);
        checkOutput("wd_halted",  32'(halted), 1);
        checkOutput("wd_timeout", 32'(timeout_err), 1);
        cyc(3);
        checkOutput("wd_run_ignored", 32'(halted), 1);
        run = 1'b0;
        pulseClear();
        checkOutput("wd_clear_timeout", 32'(timeout_err), 0);
        checkOutput("wd_clear_halted",  32'(halted), 0);

        // HALT opcode, then resume with run.
        run = 1'b1; mem_ready = 1'b1; opcode = 4'hF;
        cyc(3);
        opcode = 4'h0;
        cyc(2);
        checkOutput("hop_halted", 32'(halted), 1);
        checkOutput("hop_count",  32'(instr_count), 1);
        cyc(1);
        checkOutput("hop_resume", 32'(fetch_en), 1);
        run = 1'b0;
        cyc(4);
        checkOutput("hop_drain_count", 32'(instr_count), 2);

        // halt_req in EXEC completes the instruction, then async clear mid-FETCH.
        pulseClear();
        run = 1'b1;
        cyc(3);
        checkOutput("hr_exec", 32'(exec_en), 1);
        halt_req = 1'b1;
        cyc(1);
        halt_req = 1'b0;
        checkOutput("hr_wb", 32'(wb_en), 1);
        cyc(1);
        checkOutput("hr_halted", 32'(halted), 1);
        checkOutput("hr_count",  32'(instr_count), 1);
        cyc(1);
        checkOutput("hr_refetch", 32'(fetch_en), 1);
        #2 clear = 1'b1;
        #1;
        checkOutput("aclr_fetch_en", 32'(fetch_en), 0);
        checkOutput("aclr_mem_req",  32'(mem_req), 0);
        checkOutput("aclr_busy",     32'(busy), 0);
        checkOutput("aclr_phase",    32'(phase), 0);
        checkOutput("aclr_count",    32'(instr_count), 0);
        clear = 1'b0;
        run = 1'b0;

        // Randomized traffic in segments of varying memory responsiveness.
        for (int seg = 0; seg < 15; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 95 : ((seg % 3 == 1) ? 70 : 20);
            for (int c = 0; c < 200; c++) applyStimulus(pct);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
